rate_enable_gen: RTL and testbench

RATE_ENABLE_GEN -- requirements
Module: rate_enable_gen

---
 rtl/rate_enable_gen.sv | 117 +++++++++++
 tb/tb_rate_enable_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rate_enable_gen.sv
// Rate-selectable enable generator with a debounced single-step key.
// Free-running mode (run=1) emits a one-cycle tick every R(speed)+1 cycles.
// Paused mode (run=0) freezes the rate counter and emits one tick per accepted press.
module rate_enable_gen #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] speed,
    input  logic       run,
    input  logic       step_key,
    output logic       tick,
    output logic       pressed
);

    localparam int CW = $clog2(4 * CLK_HZ);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } db_state_t;

    logic [CW-1:0] cnt;
    logic [CW-1:0] reload;
    logic [1:0]    speed_q;
    logic          reload_pend;
    logic          rate_fire;

    logic [1:0]    key_sync;
    logic          key_s;
    db_state_t     state, state_nxt;
    logic [DW-1:0] db_cnt, db_cnt_nxt;
    logic          disagree;
    logic          step_fire;

    // Reload value for the selected rate
    always_comb begin
        reload = '0;
        case (speed)
            2'b00:   reload = '0;
            2'b01:   reload = CW'(CLK_HZ - 1);
            2'b10:   reload = CW'(2 * CLK_HZ - 1);
            default: reload = CW'(4 * CLK_HZ - 1);
        endcase
    end

    // A rate tick fires only on a plain running edge with the counter expired
    assign rate_fire = !reload_pend && (speed == speed_q) && run && (cnt == '0);

    // Rate down-counter; post-reset load and speed changes restart the period silently
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt         <= '0;
            speed_q     <= 2'b00;
            reload_pend <= 1'b1;
        end else begin
            speed_q <= speed;
            if (reload_pend) begin
                cnt         <= reload;
                reload_pend <= 1'b0;
            end else if (speed != speed_q) begin
                cnt <= reload;
            end else if (run) begin
                if (cnt == '0) cnt <= reload;
                else           cnt <= cnt - 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the raw key; idles released (high)
    always_ff @(posedge clk or posedge clear) begin
        if (clear) key_sync <= 2'b11;
        else       key_sync <= {key_sync[0], step_key};
    end

    assign key_s = key_sync[1];

    // Debounce state and disagreement counter registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state  <= UP;
            db_cnt <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // Debounce next state: flip after DEBOUNCE_CYC consecutive disagreeing samples
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = '0;
        disagree   = (state == UP) ? !key_s : key_s;
        if (disagree) begin
            if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                state_nxt  = (state == UP) ? DOWN : UP;
                db_cnt_nxt = '0;
            end else begin
                db_cnt_nxt = db_cnt + 1'b1;
            end
        end
    end

    // Accepted press while paused produces one step tick
    assign step_fire = (state == UP) && (state_nxt == DOWN) && !run;

    // Registered tick output; rate and step sources are exclusive by run
    always_ff @(posedge clk or posedge clear) begin
        if (clear) tick <= 1'b0;
        else       tick <= rate_fire | step_fire;
    end

    assign pressed = (state == DOWN);

endmodule

// File: tb/tb_rate_enable_gen.sv
// Directed bench for rate_enable_gen with CLK_HZ=4, DEBOUNCE_CYC=3.
// Per-edge tick/pressed traces are packed into vectors (bit i = edge i+1).
module tb_rate_enable_gen;

    logic       clk;
    logic       clear;
    logic [1:0] speed;
    logic       run;
    logic       step_key;
    logic       tick;
    logic       pressed;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] tv, pv;

    rate_enable_gen #(.CLK_HZ(4), .DEBOUNCE_CYC(3)) dut (
        .clk      (clk),
        .clear    (clear),
        .speed    (speed),
        .run      (run),
        .step_key (step_key),
        .tick     (tick),
        .pressed  (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive key bit i before edge i+1, record outputs 1 time unit after each edge
    task automatic run_key(input int n, input logic [31:0] kv,
                           output logic [31:0] t, output logic [31:0] p);
        t = '0;
        p = '0;
        for (int i = 0; i < n; i++) begin
            step_key = kv[i];
            @(posedge clk);
            #1;
            t[i] = tick;
            p[i] = pressed;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear    = 1'b1;
        speed    = 2'b01;
        run      = 1'b1;
        step_key = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_pressed", {31'd0, pressed}, 32'd0);

        // Release: load edge, first tick at edge 5, then every 4
        clear = 1'b0;
        run_key(13, 32'hFFFF_FFFF, tv, pv);
        chk("rel_tick", tv, 32'h0000_1110);
        chk("rel_pressed", pv, 32'h0);

        // Speed 00: change edge silent, then continuous tick
        speed = 2'b00;
        run_key(6, 32'hFFFF_FFFF, tv, pv);
        chk("spd00_tick", tv, 32'h0000_003E);

        // Speed 11: reload 15, next tick 16 cycles after change edge
        speed = 2'b11;
        run_key(20, 32'hFFFF_FFFF, tv, pv);
        chk("spd11_tick", tv, 32'h0001_0000);

        // Speed 10: reload 7 and count down to 3
        speed = 2'b10;
        run_key(5, 32'hFFFF_FFFF, tv, pv);
        chk("spd10_load", tv, 32'h0);
        run = 1'b0;
        run_key(10, 32'hFFFF_FFFF, tv, pv);
        chk("pause_tick", tv, 32'h0);
        run = 1'b1;
        run_key(6, 32'hFFFF_FFFF, tv, pv);
        chk("resume_tick", tv, 32'h0000_0008);

        // Bouncy press while paused: one step tick at edge 9
        run = 1'b0;
        run_key(16, 32'h0000_000A, tv, pv);
        chk("bounce_tick", tv, 32'h0000_0100);
        chk("bounce_pressed", pv, 32'h0000_FF00);

        // Release while paused: no tick
        run_key(8, 32'hFFFF_FFFF, tv, pv);
        chk("rel1_tick", tv, 32'h0);
        chk("rel1_pressed", pv, 32'h0000_000F);

        // Press while running: only the rate tick at edge 6
        run = 1'b1;
        run_key(12, 32'h0, tv, pv);
        chk("runpress_tick", tv, 32'h0000_0020);
        chk("runpress_pressed", pv, 32'h0000_0FF0);

        // Release while running
        run_key(8, 32'hFFFF_FFFF, tv, pv);
        chk("rel2_tick", tv, 32'h0000_0002);
        chk("rel2_pressed", pv, 32'h0000_000F);

        // Pause and press: one step tick on acceptance
        run = 1'b0;
        run_key(10, 32'h0, tv, pv);
        chk("step_tick", tv, 32'h0000_0010);
        chk("step_pressed", pv, 32'h0000_03F0);
        run_key(8, 32'hFFFF_FFFF, tv, pv);
        chk("rel3_tick", tv, 32'h0);
        chk("rel3_pressed", pv, 32'h0000_000F);

        // Speed 01 running with a press, stop with counter at 2 and key held
        speed = 2'b01;
        run   = 1'b1;
        run_key(6, 32'h0, tv, pv);
        chk("pre_clr_tick", tv, 32'h0000_0010);
        chk("pre_clr_pressed", pv, 32'h0000_0030);

        // Mid-cycle clear forces outputs immediately
        #2;
        clear    = 1'b1;
        step_key = 1'b1;
        #1;
        chk("clr_now_pressed", {31'd0, pressed}, 32'd0);
        chk("clr_now_tick", {31'd0, tick}, 32'd0);
        run_key(3, 32'hFFFF_FFFF, tv, pv);
        chk("clr_hold_tick", tv, 32'h0);
        chk("clr_hold_pressed", pv, 32'h0);
        clear = 1'b0;
        run_key(13, 32'hFFFF_FFFF, tv, pv);
        chk("rel_again_tick", tv, 32'h0000_1110);
        chk("rel_again_pressed", pv, 32'h0);

        // Clear while tick is high at speed 00; first edge after release stays silent
        speed = 2'b00;
        run_key(3, 32'hFFFF_FFFF, tv, pv);
        chk("spd00b_tick", tv, 32'h0000_0006);
        #2;
        clear = 1'b1;
        #1;
        chk("clr_tick_hi", {31'd0, tick}, 32'd0);
        run_key(2, 32'hFFFF_FFFF, tv, pv);
        clear = 1'b0;
        run_key(3, 32'hFFFF_FFFF, tv, pv);
        chk("spd00_rel_tick", tv, 32'h0000_0006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
